bch_enc_ctrl: RTL and testbench

BCH_ENC_CTRL -- requirements
Module: bch_enc_ctrl

---
 rtl/bch_pkg.sv | 14 +
 rtl/bch_lfsr_enc.sv | 31 +++
 rtl/bch_enc_ctrl.sv | 136 +++++++++++++
 tb/tb_bch_enc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared types and default BCH(31,16,t=3) constants for the serial BCH encoder controller.
package bch_pkg;

  localparam int unsigned BCH_K   = 16;
  localparam int unsigned BCH_NK  = 15;
  localparam logic [15:0] BCH_GEN = 16'h8FAF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bch_lfsr_enc.sv
// Serial systematic BCH parity generator: one message bit per enabled cycle, MSB first.
module bch_lfsr_enc
  import bch_pkg::*;
#(
  parameter int unsigned   W    = BCH_NK,
  parameter logic [W-1:0]  POLY = W'(BCH_GEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] parity
);

  logic fb;

  assign fb = bit_in ^ parity[W-1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= '0;
    end else if (clear) begin
      parity <= '0;
    end else if (shift_en) begin
      parity <= {parity[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/bch_enc_ctrl.sv
// Two-requester arbitrated serial BCH encoder; define BCH_ENC_CTRL_RR_EN for round-robin
// arbitration, otherwise requester 0 has fixed priority.
module bch_enc_ctrl
  import bch_pkg::*;
#(
  parameter int unsigned             C_INDWIDTH = BCH_K,
  parameter int unsigned             C_PARWIDTH = BCH_NK,
  parameter logic [C_PARWIDTH:0]     C_GENPOLY  = BCH_GEN
) (
  input  logic                             I_clk,
  input  logic                             I_rst_n,
  input  logic [1:0]                       I_req_valid,
  output logic [1:0]                       O_req_ready,
  input  logic [C_INDWIDTH-1:0]            I_data0,
  input  logic [C_INDWIDTH-1:0]            I_data1,
  output logic [C_INDWIDTH+C_PARWIDTH-1:0] O_codeword,
  output logic                             O_cw_valid,
  input  logic                             I_cw_ready,
  output logic                             O_cw_id,
  output logic                             O_busy
);

  localparam int unsigned     CNT_W    = $clog2(C_INDWIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_INDWIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(C_INDWIDTH);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  state_t                state, state_nxt;
  logic [1:0]            grant;
  logic                  accept;
  logic                  shift_en;
  logic                  lfsr_clear;
  logic [C_INDWIDTH-1:0] msg;
  logic [CNT_W-1:0]      cnt;
  logic [C_PARWIDTH-1:0] parity;
  logic                  cw_id;
`ifdef BCH_ENC_CTRL_RR_EN
  logic                  ptr;
`endif

  // Assertion stays asynchronous; release is retimed to I_clk so all flops leave reset together.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    grant = 2'b00;
`ifdef BCH_ENC_CTRL_RR_EN
    if (I_req_valid[ptr])       grant[ptr]  = 1'b1;
    else if (I_req_valid[~ptr]) grant[~ptr] = 1'b1;
`else
    if (I_req_valid[0])         grant = 2'b01;
    else if (I_req_valid[1])    grant = 2'b10;
`endif
  end

  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    O_req_ready = 2'b00;
    O_cw_valid  = 1'b0;
    accept      = 1'b0;
    shift_en    = 1'b0;
    lfsr_clear  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Ready is held off while the synchronised reset is still asserted.
        if (rst_n) begin
          O_req_ready = grant;
          accept      = |grant;
        end
        if (accept) begin
          lfsr_clear = 1'b1;
          state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        O_cw_valid = 1'b1;
        if (I_cw_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The message rotates rather than shifts: after C_INDWIDTH bits it is back in place for output.
  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) begin
      msg   <= '0;
      cnt   <= '0;
      cw_id <= 1'b0;
`ifdef BCH_ENC_CTRL_RR_EN
      ptr   <= 1'b0;
`endif
    end else if (accept) begin
      msg   <= grant[1] ? I_data1 : I_data0;
      cnt   <= '0;
      cw_id <= grant[1];
`ifdef BCH_ENC_CTRL_RR_EN
      ptr   <= ~grant[1];
`endif
    end else if (shift_en) begin
      msg <= {msg[C_INDWIDTH-2:0], msg[C_INDWIDTH-1]};
      if (cnt != CNT_TERM) cnt <= cnt + 1'b1;
    end
  end

  bch_lfsr_enc #(
    .W    (C_PARWIDTH),
    .POLY (C_GENPOLY[C_PARWIDTH-1:0])
  ) u_lfsr (
    .clk      (I_clk),
    .rst_n    (rst_n),
    .clear    (lfsr_clear),
    .shift_en (shift_en),
    .bit_in   (msg[C_INDWIDTH-1]),
    .parity   (parity)
  );

  assign O_codeword = {msg, parity};
  assign O_cw_id    = cw_id;
  assign O_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_bch_enc_ctrl.sv
// Directed and random checks of bch_enc_ctrl against a long-division BCH(31,16) model.
module tb_bch_enc_ctrl;

  localparam int unsigned K = 16;
  localparam int unsigned P = 15;
  localparam logic [15:0] G = 16'h8FAF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [K-1:0] data0, data1;
  logic [K+P-1:0] codeword;
  logic         cw_valid;
  logic         cw_ready;
  logic         cw_id;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bch_enc_ctrl dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid),
    .O_req_ready (req_ready),
    .I_data0     (data0),
    .I_data1     (data1),
    .O_codeword  (codeword),
    .O_cw_valid  (cw_valid),
    .I_cw_ready  (cw_ready),
    .O_cw_id     (cw_id),
    .O_busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of v modulo g(x) by textbook long division.
  function automatic logic [P-1:0] poly_rem(input logic [K+P-1:0] v);
    logic [K+P-1:0] r;
    r = v;
    for (int i = K + P - 1; i >= P; i--)
      if (r[i]) r = r ^ ((K+P)'(G) << (i - P));
    return r[P-1:0];
  endfunction

  function automatic logic [K+P-1:0] encode(input logic [K-1:0] d);
    return {d, poly_rem({d, {P{1'b0}}})};
  endfunction

  // Requests with vmask, drops the request after the accept edge and returns at the
  // negedge of the first valid cycle; lat counts cycles from the accept edge.
  task automatic run_txn(input logic [1:0] vmask, input logic [K-1:0] d0, input logic [K-1:0] d1,
                         output logic id, output logic [K+P-1:0] cw, output int lat);
    int t;
    @(posedge clk); #1;
    data0 = d0; data1 = d1; req_valid = vmask;
    t = 0;
    @(negedge clk);
    while (!(|(req_valid & req_ready)) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", 64'(t < 20), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 1;
    @(negedge clk);
    while (!cw_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    cw = codeword;
    id = cw_id;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           id;
    logic [K+P-1:0] cw, held;
    int             lat, t, vcnt;
    logic           exp_id;
    logic [K-1:0]   d;

    rst_n = 1'b0; req_valid = 2'b00; data0 = '0; data1 = '0; cw_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cw_valid", 64'(cw_valid), 64'd0);
    check("rst_codeword", 64'(codeword), 64'd0);
    check("rst_cw_id",    64'(cw_id),    64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_ready",    64'(req_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // All-zero message from requester 0, with latency.
    run_txn(2'b01, 16'h0000, 16'h0000, id, cw, lat);
    check("zero_cw",  64'(cw),  64'h0);
    check("zero_id",  64'(id),  64'd0);
    check("zero_lat", 64'(lat), 64'd17);

    // Single low bit from requester 1: parity is g(x) minus its leading term.
    run_txn(2'b10, 16'h0000, 16'h0001, id, cw, lat);
    check("one_cw", 64'(cw), 64'h0000_8FAF);
    check("one_id", 64'(id), 64'd1);

    // x^16 mod g = x * 0x0FAF with no reduction; 0x0003 is the XOR of the two.
    run_txn(2'b01, 16'h0002, 16'h0000, id, cw, lat);
    check("two_cw", 64'(cw), 64'h0001_1F5E);

    // A request raised and withdrawn between edges is never accepted.
    @(posedge clk); #1 req_valid = 2'b01;
    #3 req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("withdraw_busy", 64'(busy), 64'd0);

    // Requests toggled during SHIFT are ignored and the codeword is unaffected.
    @(posedge clk); #1 data0 = 16'h0003; req_valid = 2'b01;
    @(posedge clk); #1 req_valid = 2'b11; data0 = 16'hFFFF; data1 = 16'hFFFF;
    @(negedge clk);
    check("shift_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 req_valid = 2'b10;
    @(posedge clk); #1 req_valid = 2'b00;
    t = 0;
    @(negedge clk);
    while (!cw_valid && t < 40) begin @(negedge clk); t++; end
    check("shift_ign_to", 64'(t < 40), 64'd1);
    check("shift_ign_cw", 64'(codeword), 64'h0001_90F1);
    check("shift_ign_id", 64'(cw_id), 64'd0);

    // Back-pressure: codeword held, no grant while DONE even with both requesting.
    @(posedge clk); #1 cw_ready = 1'b0;
    run_txn(2'b01, 16'h0003, 16'h0000, id, cw, lat);
    held = cw;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_cw",    64'(codeword),  64'h0001_90F1);
      check("stall_hold",  64'(codeword),  64'(held));
      check("stall_valid", 64'(cw_valid),  64'd1);
      check("stall_ready", 64'(req_ready), 64'd0);
    end
    cw_ready = 1'b1;
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    check("stall_release_busy",  64'(busy),     64'd0);
    check("stall_release_valid", 64'(cw_valid), 64'd0);

    // Reset at bit cycle 8 of SHIFT discards the codeword.
    @(posedge clk); #1 data0 = 16'hBEEF; req_valid = 2'b01;
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",  64'(busy),     64'd0);
    check("rst_mid_valid", 64'(cw_valid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cw_valid) vcnt++;
    end
    check("rst_mid_no_valid", 64'(vcnt), 64'd0);
    run_txn(2'b10, 16'h0000, 16'h0001, id, cw, lat);
    check("rst_after_cw", 64'(cw), 64'h0000_8FAF);
    check("rst_after_id", 64'(id), 64'd1);

    // Both requesters valid continuously.
    @(posedge clk); #1 data0 = 16'h1234; data1 = 16'hABCD; req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
`ifdef BCH_ENC_CTRL_RR_EN
      exp_id = n[0];
`else
      exp_id = 1'b0;
`endif
      t = 0;
      @(negedge clk);
      while (!cw_valid && t < 60) begin @(negedge clk); t++; end
      check("arb_to", 64'(t < 60), 64'd1);
      check("arb_id", 64'(cw_id), 64'(exp_id));
      check("arb_cw", 64'(codeword), 64'(encode(exp_id ? 16'hABCD : 16'h1234)));
    end
    @(posedge clk); #1 req_valid = 2'b00;

    // Random messages against the long-division model.
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      exp_id = 1'($urandom_range(0, 1));
      if (exp_id) run_txn(2'b10, 16'($urandom), d, id, cw, lat);
      else        run_txn(2'b01, d, 16'($urandom), id, cw, lat);
      check("rnd_cw",  64'(cw), 64'(encode(d)));
      check("rnd_div", 64'(poly_rem(cw)), 64'd0);
      check("rnd_id",  64'(id), 64'(exp_id));
    end

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
